// File: rtl/map_discrete_latch.sv
// Single-register discrete-latch mapper: an M2-qualified CPU write sets the PRG/CHR banks
// and optional one-screen page, with selectable decode windows, bus conflicts and save-state.
module map_discrete_latch #(
  parameter int PRG_BITS = 2,
  parameter int CHR_BITS = 4,
  parameter int PRG_LSB  = 4,
  parameter int CHR_LSB  = 0,
  parameter int MIR_CTL  = 0,
  parameter int MIR_BIT  = 7,
  parameter int M2_FILT  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m2,
  input  logic [15:0]             cpu_addr,
  input  logic [7:0]              cpu_data,
  input  logic                    cpu_rw,
  input  logic [7:0]              prg_do,
  input  logic [1:0]              cfg_dec,
  input  logic                    cfg_bus_cf,
  input  logic                    cfg_mir_v,
  input  logic [13:0]             ppu_addr,
  input  logic                    sst_act,
  input  logic                    sst_we,
  input  logic [7:0]              sst_addr,
  input  logic [7:0]              sst_di,
  output logic [7:0]              sst_do,
  output logic                    prg_ce,
  output logic [14+PRG_BITS:0]    prg_addr,
  output logic [12+CHR_BITS:0]    chr_addr,
  output logic                    ciram_ce,
  output logic                    ciram_a10
);

  localparam int PRG_M = ((1 << PRG_BITS) - 1) << PRG_LSB;
  localparam int CHR_M = ((1 << CHR_BITS) - 1) << CHR_LSB;
  localparam int MIR_M = (MIR_CTL != 0) ? (1 << MIR_BIT) : 0;
  localparam bit CFG_OK =
    (PRG_BITS >= 1) && (PRG_BITS <= 4) && (CHR_BITS >= 1) && (CHR_BITS <= 4) &&
    (PRG_LSB >= 0) && (PRG_LSB + PRG_BITS <= 8) &&
    (CHR_LSB >= 0) && (CHR_LSB + CHR_BITS <= 8) &&
    (MIR_BIT >= 0) && (MIR_BIT <= 7) &&
    ((PRG_M & CHR_M) == 0) && ((PRG_M & MIR_M) == 0) && ((CHR_M & MIR_M) == 0) &&
    (M2_FILT >= 1) && (M2_FILT <= 7);

  generate
    if (!CFG_OK) begin : g_cfg_err
      $fatal(1, "map_discrete_latch: illegal field layout or M2_FILT");
    end
  endgenerate

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HIGH   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic                r_m2_s1, r_m2_s2, r_m2_d;
  logic                r_sync_vld, r_armed;
  logic [2:0]          r_cnt;
  logic [15:0]         r_sh_addr;
  logic [7:0]          r_sh_data, r_sh_prg;
  logic                r_sh_rw;
  logic [1:0]          r_state;
  logic [PRG_BITS-1:0] r_prg_bank;
  logic [CHR_BITS-1:0] r_chr_bank;
  logic                r_mir;
  logic [7:0]          r_raw;

  logic                w_hit, w_valid, w_rise, w_load, w_commit;
  logic [7:0]          w_val, w_byte;

  always_comb begin
    w_hit = 1'b0;
    case (cfg_dec)
      2'd0: w_hit = r_sh_addr[15] || (r_sh_addr[15:12] == 4'h6);
      2'd1: w_hit = (r_sh_addr[15:14] == 2'b10);
      2'd2: w_hit = (r_sh_addr[15:12] == 4'h7);
      default: w_hit = r_sh_addr[15];
    endcase
  end

  assign w_valid  = (r_cnt >= 3'(M2_FILT)) && !r_sh_rw && w_hit;
  assign w_rise   = r_m2_s2 && !r_m2_d && r_armed;
  assign w_val    = r_sh_data & ((cfg_bus_cf && r_sh_addr[15]) ? r_sh_prg : 8'hFF);
  assign w_load   = sst_we && (sst_addr == 8'h00);
  assign w_commit = (r_state == S_COMMIT) && !sst_act;
  assign w_byte   = w_load ? sst_di : w_val;

  // r_armed only sets once the synchronised pin is seen low after reset, so an M2
  // that is already high at release cannot fake a rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m2_s1    <= 1'b0;
      r_m2_s2    <= 1'b0;
      r_m2_d     <= 1'b0;
      r_sync_vld <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_m2_s1    <= m2;
      r_m2_s2    <= r_m2_s1;
      r_m2_d     <= r_m2_s2;
      r_sync_vld <= 1'b1;
      if (r_sync_vld && !r_m2_s1) r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= 3'd0;
      r_sh_addr <= 16'h0000;
      r_sh_data <= 8'h00;
      r_sh_prg  <= 8'h00;
      r_sh_rw   <= 1'b0;
    end else if (r_m2_s2) begin
      if (r_cnt != 3'd7) r_cnt <= r_cnt + 3'd1;
      r_sh_addr <= cpu_addr;
      r_sh_data <= cpu_data;
      r_sh_prg  <= prg_do;
      r_sh_rw   <= cpu_rw;
    end else begin
      r_cnt <= 3'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else if (sst_act) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (w_rise) r_state <= S_HIGH;
        S_HIGH:   if (!r_m2_s2) r_state <= w_valid ? S_COMMIT : S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Save-state load shares the extraction path and takes priority over a commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prg_bank <= '0;
      r_chr_bank <= '0;
      r_mir      <= 1'b0;
      r_raw      <= 8'h00;
    end else if (w_load || w_commit) begin
      r_prg_bank <= w_byte[PRG_LSB +: PRG_BITS];
      r_chr_bank <= w_byte[CHR_LSB +: CHR_BITS];
      r_mir      <= w_byte[MIR_BIT];
      r_raw      <= w_byte;
    end
  end

  assign prg_ce    = cpu_addr[15];
  assign prg_addr  = {r_prg_bank, cpu_addr[14:0]};
  assign chr_addr  = {r_chr_bank, ppu_addr[12:0]};
  assign ciram_ce  = !ppu_addr[13];
  assign ciram_a10 = (MIR_CTL != 0) ? r_mir : (cfg_mir_v ? ppu_addr[10] : ppu_addr[11]);
  assign sst_do    = (sst_addr == 8'h00) ? r_raw : 8'hFF;

endmodule
